// File: rtl/hpm_counter_bank.sv
// Bank of programmable hardware performance counters with event selectors.
// It adds a registered event stage, multi-count events and overflow interrupt generation.
module hpm_counter_bank #(
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int XLEN           = 64,
  parameter int NUM_EVENTS     = 28,
  parameter int EVENT_WIDTH    = 2,
  parameter int NUM_COUNTERS   = 29,
  parameter int COUNTER_WIDTH  = 64
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic [CSR_ADDR_WIDTH-1:0]         addr_i,
  input  logic                              we_i,
  input  logic [XLEN-1:0]                   data_i,
  output logic [XLEN-1:0]                   data_o,
  input  logic [31:0]                       mcountinhibit_i,
  input  logic [1:0]                        priv_lvl_i,
  input  logic [NUM_EVENTS*EVENT_WIDTH-1:0] events_i,
  output logic                              count_ovf_int_req_o,
  output logic [NUM_COUNTERS+2:3]           mhpm_ovf_bits_o
);

  if (XLEN != 64) begin : g_bad_xlen
    $error("hpm_counter_bank: XLEN must be 64");
  end

  localparam int CW1 = COUNTER_WIDTH + 1;
  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [CSR_ADDR_WIDTH-1:0] CNT_BASE = CSR_ADDR_WIDTH'(12'hB00);
  localparam logic [CSR_ADDR_WIDTH-1:0] EVT_BASE = CSR_ADDR_WIDTH'(12'h320);

  logic                              cnt_hit;
  logic                              evt_hit;
  logic [4:0]                        idx;
  logic [NUM_EVENTS*EVENT_WIDTH-1:0] ev_q;
  logic [1:0]                        priv_q;
  logic [COUNTER_WIDTH-1:0]          cnt_q   [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0]          cnt_d   [NUM_COUNTERS];
  logic [XLEN-1:0]                   evsel_q [NUM_COUNTERS];
  logic [XLEN-1:0]                   evsel_d [NUM_COUNTERS];
  logic [EVENT_WIDTH-1:0]            inc     [NUM_COUNTERS];
  logic [COUNTER_WIDTH:0]            sum     [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]           count_en;
  logic                              ovf_int_q;
  logic                              ovf_int_d;
  logic                              unused_inhibit;

  assign idx            = addr_i[4:0];
  assign cnt_hit        = (addr_i[CSR_ADDR_WIDTH-1:5] == CNT_BASE[CSR_ADDR_WIDTH-1:5]);
  assign evt_hit        = (addr_i[CSR_ADDR_WIDTH-1:5] == EVT_BASE[CSR_ADDR_WIDTH-1:5]);
  assign unused_inhibit = ^mcountinhibit_i[2:0];

  // Selector decode: out-of-range selectors leave count_en low, so they never count.
  always_comb begin
    for (int j = 0; j < NUM_COUNTERS; j++) begin
      inc[j]      = '0;
      count_en[j] = 1'b0;
      for (int e = 1; e <= NUM_EVENTS; e++) begin
        if (evsel_q[j][55:0] == 56'(e)) begin
          inc[j]      = ev_q[(e-1)*EVENT_WIDTH +: EVENT_WIDTH];
          count_en[j] = 1'b1;
        end
      end
      case (priv_q)
        PRIV_M:  if (evsel_q[j][62]) count_en[j] = 1'b0;
        PRIV_S:  if (evsel_q[j][61]) count_en[j] = 1'b0;
        PRIV_U:  if (evsel_q[j][60]) count_en[j] = 1'b0;
        default: ;
      endcase
      if (mcountinhibit_i[j+3]) count_en[j] = 1'b0;
    end
  end

  // A CSR counter write drops that cycle's increment; a selector write overrides the OF set.
  always_comb begin
    ovf_int_d = 1'b0;
    for (int j = 0; j < NUM_COUNTERS; j++) begin
      sum[j]     = {1'b0, cnt_q[j]} + CW1'(inc[j]);
      cnt_d[j]   = cnt_q[j];
      evsel_d[j] = evsel_q[j];
      if (we_i && cnt_hit && (int'(idx) == j + 3)) begin
        cnt_d[j] = data_i[COUNTER_WIDTH-1:0];
      end else if (count_en[j]) begin
        cnt_d[j] = sum[j][COUNTER_WIDTH-1:0];
        if (sum[j][COUNTER_WIDTH] && !evsel_q[j][63]) begin
          evsel_d[j][63] = 1'b1;
          ovf_int_d      = 1'b1;
        end
      end
      if (we_i && evt_hit && (int'(idx) == j + 3)) begin
        evsel_d[j] = {data_i[63:60], 4'b0000, data_i[55:0]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ev_q      <= '0;
      priv_q    <= '0;
      ovf_int_q <= 1'b0;
      for (int j = 0; j < NUM_COUNTERS; j++) begin
        cnt_q[j]   <= '0;
        evsel_q[j] <= '0;
      end
    end else begin
      ev_q      <= events_i;
      priv_q    <= priv_lvl_i;
      ovf_int_q <= ovf_int_d;
      for (int j = 0; j < NUM_COUNTERS; j++) begin
        cnt_q[j]   <= cnt_d[j];
        evsel_q[j] <= evsel_d[j];
      end
    end
  end

  always_comb begin
    data_o = '0;
    for (int j = 0; j < NUM_COUNTERS; j++) begin
      if (int'(idx) == j + 3) begin
        if (cnt_hit) data_o = XLEN'(cnt_q[j]);
        if (evt_hit) data_o = evsel_q[j];
      end
    end
  end

  always_comb begin
    mhpm_ovf_bits_o = '0;
    for (int j = 0; j < NUM_COUNTERS; j++) begin
      mhpm_ovf_bits_o[j+3] = evsel_q[j][63];
    end
  end

  assign count_ovf_int_req_o = ovf_int_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomized bench for hpm_counter_bank against a cycle-level behavioural model of the
// counter bank (48-bit counters, 8 implemented counters, 28 two-bit events).
module tb_hpm_counter_bank;

  localparam int NC = 8;
  localparam int CW = 48;
  localparam int NE = 28;
  localparam int EW = 2;
  localparam logic [63:0] CMASK = 64'h0000_FFFF_FFFF_FFFF;
  localparam logic [63:0] EMASK = 64'hF0FF_FFFF_FFFF_FFFF;

  logic              clk;
  logic              rstn;
  logic [11:0]       addr;
  logic              we;
  logic [63:0]       wdata;
  logic [63:0]       rdata;
  logic [31:0]       minh;
  logic [1:0]        priv;
  logic [NE*EW-1:0]  events;
  logic              irq;
  logic [NC+2:3]     ovf_bits;

  hpm_counter_bank #(
    .CSR_ADDR_WIDTH(12), .XLEN(64), .NUM_EVENTS(NE), .EVENT_WIDTH(EW),
    .NUM_COUNTERS(NC), .COUNTER_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .addr_i(addr), .we_i(we), .data_i(wdata),
    .data_o(rdata), .mcountinhibit_i(minh), .priv_lvl_i(priv), .events_i(events),
    .count_ovf_int_req_o(irq), .mhpm_ovf_bits_o(ovf_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
  endtask

  // Reference model state: architectural CSR values indexed by CSR number.
  logic [63:0]      m_cnt [32];
  logic [63:0]      m_evt [32];
  logic [NE*EW-1:0] m_ev;
  logic [1:0]       m_priv;
  logic             m_irq;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = '0;
      m_evt[i] = '0;
    end
    m_ev = '0; m_priv = '0; m_irq = 1'b0;
  endtask

  function automatic logic [63:0] m_read(input logic [11:0] a);
    if (a >= 12'hB03 && int'(a) <= 'hB00 + NC + 2) return m_cnt[a - 12'hB00];
    if (a >= 12'h323 && int'(a) <= 'h320 + NC + 2) return m_evt[a - 12'h320];
    return '0;
  endfunction

  // One clock edge: events seen last cycle are added now, with the current inhibit mask.
  task automatic model_step();
    logic [63:0] nc [32];
    logic [63:0] ne [32];
    logic        irq_n;
    longint unsigned sel, amount, total;
    logic inh, counting;
    irq_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      nc[i] = m_cnt[i];
      ne[i] = m_evt[i];
    end
    for (int i = 3; i <= NC + 2; i++) begin
      sel = m_evt[i][55:0];
      case (m_priv)
        2'b11:   inh = m_evt[i][62];
        2'b01:   inh = m_evt[i][61];
        2'b00:   inh = m_evt[i][60];
        default: inh = 1'b0;
      endcase
      counting = !minh[i] && sel >= 1 && sel <= NE && !inh;
      amount = counting ? longint'((m_ev >> (EW * int'(sel - 1))) & 3) : 0;
      if (we && int'(addr) == 'hB00 + i) begin
        nc[i] = wdata & CMASK;
      end else begin
        total = m_cnt[i] + amount;
        if (total > CMASK) begin
          nc[i] = total - (CMASK + 1);
          if (!m_evt[i][63]) begin
            ne[i][63] = 1'b1;
            irq_n = 1'b1;
          end
        end else begin
          nc[i] = total;
        end
      end
      if (we && int'(addr) == 'h320 + i) ne[i] = wdata & EMASK;
    end
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = nc[i];
      m_evt[i] = ne[i];
    end
    m_irq = irq_n; m_ev = events; m_priv = priv;
  endtask

  task automatic cycle();
    logic [NC-1:0] eb;
    @(negedge clk);
    check($sformatf("rd@%h", addr), rdata, m_read(addr));
    check("irq", 64'(irq), 64'(m_irq));
    for (int i = 3; i <= NC + 2; i++) eb[i-3] = m_evt[i][63];
    check("ovf_bits", 64'(ovf_bits), 64'(eb));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    addr = a; we = 1'b1; wdata = d;
    cycle();
    we = 1'b0; wdata = '0;
  endtask

  task automatic set_ev(input int e, input logic [1:0] v);
    events[(e-1)*EW +: EW] = v;
  endtask

  logic [11:0] rst_addrs [5];

  initial begin
    rstn = 1'b1; addr = '0; we = 1'b0; wdata = '0; minh = '0; priv = 2'b11;
    events = '1;
    model_reset();
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    rst_addrs = '{12'hB03, 12'hB0A, 12'h323, 12'h32A, 12'hB00};
    foreach (rst_addrs[k]) begin
      addr = rst_addrs[k];
      #1;
      check("rst_rd", rdata, 64'd0);
    end
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_ovf_bits", 64'(ovf_bits), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    addr = 12'hB03;
    repeat (4) cycle();
    check("idle_cnt3", rdata, 64'd0);
    events = '0;

    // Multi-count event into counter 3.
    wr(12'h323, 64'd1);
    set_ev(1, 2'd3);
    addr = 12'hB03;
    repeat (4) cycle();
    set_ev(1, 2'd0);
    repeat (3) cycle();
    check("cnt3_hold", rdata, 64'd12);

    // 48-bit wrap with and without OF already set.
    wr(12'h324, 64'd2);
    wr(12'hB04, 64'h0000_FFFF_FFFF_FFFE);
    set_ev(2, 2'd2);
    addr = 12'hB04;
    cycle();
    set_ev(2, 2'd0);
    cycle();
    check("wrap1_cnt", rdata, 64'd0);
    check("wrap1_irq", 64'(irq), 64'd1);
    check("wrap1_of", 64'(ovf_bits[4]), 64'd1);
    cycle();
    check("wrap1_irq_end", 64'(irq), 64'd0);
    wr(12'hB04, 64'h0000_FFFF_FFFF_FFFF);
    set_ev(2, 2'd1);
    cycle();
    set_ev(2, 2'd0);
    cycle();
    check("wrap2_cnt", rdata, 64'd0);
    check("wrap2_irq", 64'(irq), 64'd0);
    check("wrap2_of", 64'(ovf_bits[4]), 64'd1);

    // Privilege filtering and mcountinhibit.
    wr(12'h325, 64'h4000_0000_0000_0002);
    set_ev(2, 2'd1);
    addr = 12'hB05;
    repeat (3) cycle();
    check("minh_m", rdata, 64'd0);
    priv = 2'b00;
    repeat (3) cycle();
    check("minh_u", rdata, 64'd2);
    minh[5] = 1'b1;
    repeat (3) cycle();
    check("mcountinhibit", rdata, 64'd2);
    minh = '0;
    set_ev(2, 2'd0);

    // Write beats a pending increment; selector WARL mask.
    wr(12'h326, 64'd1);
    set_ev(1, 2'd2);
    addr = 12'hB06;
    repeat (3) cycle();
    set_ev(1, 2'd0);
    wr(12'hB06, 64'h100);
    check("wr_prio", rdata, 64'h100);
    wr(12'h326, '1);
    check("evt_warl", rdata, 64'hF0FF_FFFF_FFFF_FFFF);

    // Unimplemented index and out-of-range selector.
    wr(12'hB1F, 64'd12345);
    check("unimpl_cnt", rdata, 64'd0);
    wr(12'h33F, 64'd5);
    check("unimpl_evt", rdata, 64'd0);
    wr(12'h327, 64'd29);
    events = '1;
    addr = 12'hB07;
    repeat (4) cycle();
    check("sel29", rdata, 64'd0);
    events = '0;

    // Randomized traffic, with one asynchronous reset mid-run.
    for (int n = 0; n < 400; n++) begin
      int r;
      events = {$urandom, $urandom};
      priv   = 2'($urandom);
      minh   = $urandom & $urandom & $urandom;
      we     = ($urandom_range(0, 7) == 0);
      r      = $urandom_range(0, 9);
      if (r < 5)      addr = 12'hB00 + 12'($urandom_range(3, 12));
      else if (r < 8) addr = 12'h320 + 12'($urandom_range(3, 12));
      else if (r < 9) addr = 12'hB00 + 12'($urandom_range(0, 31));
      else            addr = 12'($urandom);
      if (addr[11:8] == 4'hB)
        wdata = $urandom_range(0, 1) ? (64'h0000_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255)))
                                     : {$urandom, $urandom};
      else
        wdata = {4'($urandom), 4'($urandom), 24'($urandom), 32'($urandom_range(0, 31))};
      cycle();
      if (n == 200) begin
        we = 1'b0;
        addr = 12'hB03;
        rstn = 1'b0;
        #1;
        check("midrst_rd", rdata, 64'd0);
        check("midrst_irq", 64'(irq), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
      end
    end
    we = 1'b0;
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
